// File: rtl/addr_remap_pipe.sv
// Registered bridge-to-system-bus address translator with a programmable window table.
// Optional per-window offset limit check: define ADDR_REMAP_BOUND_CHECK_EN.
module addr_remap_pipe #(
  parameter int unsigned BB_ADDR_WIDTH      = 12,
  parameter int unsigned BUS_ADDR_WIDTH     = 16,
  parameter int unsigned BUS_MEM_ADDR_WIDTH = 12,
  parameter int unsigned NUM_WIN            = 2,
  localparam int unsigned WIN_BITS          = $clog2(NUM_WIN),
  localparam int unsigned SID_W             = BUS_ADDR_WIDTH - BUS_MEM_ADDR_WIDTH,
  localparam int unsigned OFF_W             = BB_ADDR_WIDTH - WIN_BITS
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BB_ADDR_WIDTH-1:0]  in_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BUS_ADDR_WIDTH-1:0] out_addr,
  output logic                      out_err,
  input  logic                      cfg_we,
  input  logic [WIN_BITS-1:0]       cfg_idx,
  input  logic [SID_W-1:0]          cfg_sid,
  input  logic                      cfg_en,
  input  logic [OFF_W-1:0]          cfg_limit
);

  if (OFF_W > BUS_MEM_ADDR_WIDTH) begin : g_bad_offset_width
    $error("addr_remap_pipe: offset width exceeds BUS_MEM_ADDR_WIDTH");
  end
  if (NUM_WIN < 2 || (NUM_WIN & (NUM_WIN - 1)) != 0) begin : g_bad_num_win
    $error("addr_remap_pipe: NUM_WIN must be a power of two and at least 2");
  end

  logic [SID_W-1:0] r_sid [NUM_WIN];
  logic             r_en  [NUM_WIN];

  logic                          r_valid;
  logic [BUS_ADDR_WIDTH-1:0]     r_addr;
  logic                          r_err;

  logic [WIN_BITS-1:0]           w_win;
  logic [OFF_W-1:0]              w_off;
  logic [BUS_MEM_ADDR_WIDTH-1:0] w_off_ext;
  logic                          w_oob;
  logic                          w_hit_ok;
  logic                          w_accept;
  logic [BUS_ADDR_WIDTH-1:0]     w_xlate;

  assign w_win = in_addr[BB_ADDR_WIDTH-1 -: WIN_BITS];
  assign w_off = in_addr[OFF_W-1:0];

  always_comb begin
    w_off_ext             = '0;
    w_off_ext[OFF_W-1:0]  = w_off;
  end

`ifdef ADDR_REMAP_BOUND_CHECK_EN
  logic [OFF_W-1:0] r_limit [NUM_WIN];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_WIN; i++) r_limit[i] <= '1;
    end else if (cfg_we) begin
      r_limit[cfg_idx] <= cfg_limit;
    end
  end

  assign w_oob = (w_off > r_limit[w_win]);
`else
  logic w_unused_limit;
  assign w_unused_limit = ^cfg_limit;
  assign w_oob          = 1'b0;
`endif

  // Table reads here see the pre-write entry when cfg_we coincides with an accept.
  assign w_hit_ok = r_en[w_win] & ~w_oob;
  assign w_xlate  = w_hit_ok ? {r_sid[w_win], w_off_ext} : '0;
  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_WIN; i++) begin
        r_sid[i] <= SID_W'(i);
        r_en[i]  <= 1'b1;
      end
    end else if (cfg_we) begin
      r_sid[cfg_idx] <= cfg_sid;
      r_en[cfg_idx]  <= cfg_en;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_addr  <= w_xlate;
      r_err   <= ~w_hit_ok;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_err   = r_err;

endmodule

// File: tb/tb_addr_remap_pipe.sv
// Self-checking bench for addr_remap_pipe: directed scenarios followed by random traffic
// checked against a window-table reference model.
module tb_addr_remap_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_addr;
  logic        out_err;
  logic        cfg_we;
  logic [0:0]  cfg_idx;
  logic [3:0]  cfg_sid;
  logic        cfg_en;
  logic [10:0] cfg_limit;

  always #5 clk = ~clk;

  addr_remap_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .cfg_we    (cfg_we),
    .cfg_idx   (cfg_idx),
    .cfg_sid   (cfg_sid),
    .cfg_en    (cfg_en),
    .cfg_limit (cfg_limit)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: window table plus the single beat the translator is holding.
  int m_sid   [2];
  bit m_en    [2];
  int m_limit [2];
  bit m_valid;
  int m_addr;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_sid[i]   = i;
      m_en[i]    = 1'b1;
      m_limit[i] = 'h7FF;
    end
    m_valid = 1'b0;
    m_addr  = 0;
    m_err   = 1'b0;
  endtask

  task automatic xlate(input int addr, output int a, output bit e);
    int w, off;
    bit oob;
    w   = addr / 'h800;
    off = addr % 'h800;
    oob = 1'b0;
`ifdef ADDR_REMAP_BOUND_CHECK_EN
    oob = off > m_limit[w];
`endif
    if (!m_en[w] || oob) begin
      a = 0;
      e = 1'b1;
    end else begin
      a = m_sid[w] * 'h1000 + off;
      e = 1'b0;
    end
  endtask

  // One clock: present inputs at the falling edge, check handshake, then check the output beat.
  task automatic step(input bit v, input int addr, input bit rdy,
                      input bit we = 0, input int idx = 0, input int sid = 0,
                      input bit en = 1, input int lim = 'h7FF);
    bit exp_rdy, acc, ne;
    int na;
    in_valid  = v;
    in_addr   = 12'(addr);
    out_ready = rdy;
    cfg_we    = we;
    cfg_idx   = 1'(idx);
    cfg_sid   = 4'(sid);
    cfg_en    = en;
    cfg_limit = 11'(lim);
    #1;
    exp_rdy = !m_valid || rdy;
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    acc = v && exp_rdy;
    if (acc) xlate(addr, na, ne);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_addr  = na;
      m_err   = ne;
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    if (we) begin
      m_sid[idx]   = sid;
      m_en[idx]    = en;
      m_limit[idx] = lim;
    end
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    if (m_valid) begin
      chk("out_addr", {16'b0, out_addr}, m_addr);
      chk("out_err", {31'b0, out_err}, {31'b0, m_err});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    in_valid = 0; in_addr = '0; out_ready = 0;
    cfg_we = 0; cfg_idx = '0; cfg_sid = '0; cfg_en = 0; cfg_limit = '0;
    do_reset();
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_addr", {16'b0, out_addr}, 0);
    chk("rst_out_err", {31'b0, out_err}, 0);

    // T1 reset mapping
    step(1, 'h812, 1);
    chk("t1_a", {16'b0, out_addr}, 'h1012);
    step(1, 'h034, 1);
    chk("t1_b", {16'b0, out_addr}, 'h0034);

    // T2 remap, then write coinciding with accept uses the old entry
    step(0, 0, 1, 1, 0, 'hA, 1);
    step(1, 'h7FF, 1);
    chk("t2_a", {16'b0, out_addr}, 'hA7FF);
    step(0, 0, 1, 1, 0, 'h0, 1);
    step(1, 'h7FF, 1, 1, 0, 'hA, 1);
    chk("t2_b", {16'b0, out_addr}, 'h07FF);

    // T3 disabled window still yields a handshaken error beat
    step(0, 0, 1, 1, 1, 1, 0);
    step(1, 'h800, 1);
    chk("t3_err", {31'b0, out_err}, 1);
    chk("t3_addr", {16'b0, out_addr}, 0);
    step(1, 'h055, 1);
    chk("t3_next", {16'b0, out_addr}, 'hA055);
    step(0, 0, 1, 1, 1, 1, 1);

    // T4 backpressure: first beat held four cycles, then three in order
    step(1, 'h811, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 'h822, 0);
      chk("t4_hold", {16'b0, out_addr}, 'h1011);
    end
    step(1, 'h822, 1);
    chk("t4_b2", {16'b0, out_addr}, 'h1022);
    step(1, 'h033, 1);
    chk("t4_b3", {16'b0, out_addr}, 'hA033);
    step(0, 0, 1);

    // T5 offset limit on window 0
    step(0, 0, 1, 1, 0, 0, 1, 'h0FF);
    step(1, 'h100, 1);
`ifdef ADDR_REMAP_BOUND_CHECK_EN
    chk("t5_oob_err", {31'b0, out_err}, 1);
`else
    chk("t5_oob_err", {31'b0, out_err}, 0);
`endif
    step(1, 'h0FF, 1);
    chk("t5_in_addr", {16'b0, out_addr}, 'h00FF);
    chk("t5_in_err", {31'b0, out_err}, 0);

    // T6 reset while a beat is held
    step(1, 'h812, 0);
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("t6_valid_drop", {31'b0, out_valid}, 0);
    @(negedge clk);
    rstn = 1'b1;
    step(1, 'h812, 1);
    chk("t6_t1_a", {16'b0, out_addr}, 'h1012);
    step(1, 'h034, 1);
    chk("t6_t1_b", {16'b0, out_addr}, 'h0034);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 'hFFF)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0,
           int'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, int'($urandom_range(0, 'h7FF)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
